// File: rtl/ps2_note_pkg.sv
// ps2_note_pkg: shared definitions for the PS/2 note decoder.
//   - scan codes for the E0/F0 prefixes and the 13 piano keys
//   - NOTE_SILENT, the note value meaning "no key held"
//   - map_code(): scan code -> {hit, note}
//   - frame-receiver and key FSM state encodings
package ps2_note_pkg;

  localparam logic [7:0] NOTE_SILENT = 8'd99;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // naturals
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;
  // sharps
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_T = 8'h2C;
  localparam logic [7:0] SC_Y = 8'h35;
  localparam logic [7:0] SC_U = 8'h3C;

  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_PARITY,
    F_STOP
  } frame_state_e;

  // Key FSM state is the pair of pending prefix flags: bit1 = ext, bit0 = brk.
  typedef enum logic [1:0] {
    K_IDLE    = 2'b00,
    K_BRK     = 2'b01,
    K_EXT     = 2'b10,
    K_EXT_BRK = 2'b11
  } key_state_e;

  // Returns {hit, note}. note is NOTE_SILENT when hit is 0.
  function automatic logic [8:0] map_code(input logic [7:0] code);
    logic [8:0] r;
    case (code)
      SC_A:    r = {1'b1, 8'd1};
      SC_S:    r = {1'b1, 8'd2};
      SC_D:    r = {1'b1, 8'd3};
      SC_F:    r = {1'b1, 8'd4};
      SC_G:    r = {1'b1, 8'd5};
      SC_H:    r = {1'b1, 8'd6};
      SC_J:    r = {1'b1, 8'd7};
      SC_K:    r = {1'b1, 8'd8};
      SC_W:    r = {1'b1, 8'd9};
      SC_E:    r = {1'b1, 8'd10};
      SC_T:    r = {1'b1, 8'd11};
      SC_Y:    r = {1'b1, 8'd12};
      SC_U:    r = {1'b1, 8'd13};
      default: r = {1'b0, NOTE_SILENT};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_note_decoder_rx.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver.
//   Synchronizes the PS/2 lines, detects falling clock edges, assembles
//   start/8 data/odd parity/stop frames and aborts a frame that stalls.
// Ports:
//   clk, rst_n     system clock, async active-low reset
//   ps2_clk/dat    raw PS/2 lines (asynchronous)
//   data_byte      last received byte, valid while byte_strobe is high
//   byte_strobe    1-cycle pulse, cycle after a good stop bit
//   frame_err      1-cycle pulse on parity error, bad stop bit or timeout
module ps2_rx_frame
  import ps2_note_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data_byte,
  output logic       byte_strobe,
  output logic       frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]   clk_sync, dat_sync;
  logic         clk_prev;
  logic         fall, dat;
  frame_state_e state_q, state_n;
  logic [2:0]   bit_cnt;
  logic [7:0]   shift_q;
  logic         par_ok;
  logic [CW-1:0] tmo_cnt;
  logic         timeout;
  logic         strobe_n, err_n;

  // Sync FFs reset to 1 (idle bus) so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[1];
  assign dat     = dat_sync[1];
  assign timeout = (state_q != F_IDLE) && !fall && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n  = state_q;
    strobe_n = 1'b0;
    err_n    = 1'b0;
    case (state_q)
      F_IDLE:   if (fall && !dat) state_n = F_DATA;
      F_DATA:   if (fall && bit_cnt == 3'd7) state_n = F_PARITY;
      F_PARITY: if (fall) state_n = F_STOP;
      F_STOP: begin
        if (fall) begin
          state_n = F_IDLE;
          if (dat && par_ok) strobe_n = 1'b1;
          else               err_n    = 1'b1;
        end
      end
      default:  state_n = F_IDLE;
    endcase
    if (timeout) begin
      state_n = F_IDLE;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= F_IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      par_ok      <= 1'b0;
      tmo_cnt     <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_n;
      byte_strobe <= strobe_n;
      frame_err   <= err_n;
      // Counts consecutive edge-free cycles while a frame is in flight.
      if (state_q == F_IDLE || fall) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + 1'b1;
      if (fall) begin
        case (state_q)
          F_IDLE:   bit_cnt <= '0;
          F_DATA: begin
            shift_q <= {dat, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          F_PARITY: par_ok <= ^{shift_q, dat};
          default: ;
        endcase
      end
    end
  end

  // shift_q is frozen from the parity bit until the next start bit.
  assign data_byte = shift_q;

endmodule

// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder: turns PS/2 keyboard scan codes into a piano note index.
//   Tracks E0/F0 prefixes; the last mapped key pressed owns oNote, and its
//   release returns oNote to NOTE_SILENT. Extended-prefix codes are ignored.
// Ports:
//   iClk, iReset_n   system clock, async active-low reset
//   iPs2_Clk/Dat     raw PS/2 lines
//   oNote            1..13 while a mapped key is held, NOTE_SILENT otherwise
//   oNoteValid       1-cycle pulse when oNote changes
//   oFrameErr        1-cycle pulse on a bad or stalled frame
module ps2_note_decoder
  import ps2_note_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iPs2_Clk,
  input  logic       iPs2_Dat,
  output logic [7:0] oNote,
  output logic       oNoteValid,
  output logic       oFrameErr
);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  key_state_e key_q, key_n;
  logic [7:0] note_q, note_n;
  logic       vld_n;
  logic [8:0] map_res;
  logic       ext, brk;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk         (iClk),
    .rst_n       (iReset_n),
    .ps2_clk     (iPs2_Clk),
    .ps2_dat     (iPs2_Dat),
    .data_byte   (rx_byte),
    .byte_strobe (rx_strobe),
    .frame_err   (oFrameErr)
  );

  assign ext = (key_q == K_EXT) || (key_q == K_EXT_BRK);
  assign brk = (key_q == K_BRK) || (key_q == K_EXT_BRK);

  // A frame error produces no strobe, so pending prefixes simply persist.
  always_comb begin
    key_n   = key_q;
    note_n  = note_q;
    vld_n   = 1'b0;
    map_res = map_code(rx_byte);
    if (rx_strobe) begin
      if (rx_byte == SC_EXT) begin
        key_n = brk ? K_EXT_BRK : K_EXT;
      end else if (rx_byte == SC_BRK) begin
        key_n = ext ? K_EXT_BRK : K_BRK;
      end else begin
        key_n = K_IDLE;
        if (!ext && map_res[8]) begin
          if (!brk && map_res[7:0] != note_q) begin
            note_n = map_res[7:0];
            vld_n  = 1'b1;
          end else if (brk && map_res[7:0] == note_q) begin
            note_n = NOTE_SILENT;
            vld_n  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      key_q      <= K_IDLE;
      note_q     <= NOTE_SILENT;
      oNoteValid <= 1'b0;
    end else begin
      key_q      <= key_n;
      note_q     <= note_n;
      oNoteValid <= vld_n;
    end
  end

  assign oNote = note_q;

endmodule
